// File: rtl/dataflow_arb_pkg.sv
// Shared types and constants for the dataflow round-robin arbiter and its picker.
package dataflow_arb_pkg;

    localparam int unsigned MAX_NUM_REQ = 16;
    localparam int unsigned COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRelease
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-by-ptr priority encoder: first set req bit at or above ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                valid,
    output logic [ID_WIDTH-1:0] idx
);

    logic [2*NUM_REQ-1:0] rotated;
    logic [ID_WIDTH-1:0]  offset;
    logic [ID_WIDTH:0]    sum;

    always_comb begin
        // Doubling the vector turns the wrap-around scan into a plain shift.
        rotated = {req, req} >> ptr;
        offset  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = ID_WIDTH'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
            sum = sum - (ID_WIDTH + 1)'(NUM_REQ);
        end
        valid = |req;
        idx   = sum[ID_WIDTH-1:0];
    end

endmodule

// File: rtl/dataflow_rr_arbiter.sv
// Round-robin arbiter letting NUM_REQ req/ack requesters share one upstream source,
// forwarding one token per grant and counting delivered tokens.
module dataflow_rr_arbiter
    import dataflow_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_in,
    output logic [NUM_REQ-1:0]     ack_out,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   req_up,
    input  logic                   ack_up,
    input  logic [DATA_WIDTH-1:0]  din_up,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   proto_err
);

    arb_state_e state_q, state_d;

    logic [ID_WIDTH-1:0]    ptr_q;
    logic [ID_WIDTH-1:0]    grant_id_q;
    logic                   req_up_q;
    logic [NUM_REQ-1:0]     ack_out_q;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   proto_err_q;

    logic                   pick_valid;
    logic [ID_WIDTH-1:0]    pick_idx;
    logic [ID_WIDTH-1:0]    ptr_next;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_picker (
        .req  (req_in),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    assign ptr_next = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pick_valid) state_d = StReq;
            StReq:     if (ack_up) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            grant_id_q  <= '0;
            req_up_q    <= 1'b0;
            ack_out_q   <= '0;
            dout_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // An ack outside REQ has no grant to deliver to; drop it and flag.
            if (ack_up && state_q != StReq) begin
                proto_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_id_q <= pick_idx;
                        req_up_q   <= 1'b1;
                    end
                end
                StReq: begin
                    if (ack_up) begin
                        dout_q    <= din_up;
                        ack_out_q <= NUM_REQ'(1) << grant_id_q;
                        req_up_q  <= 1'b0;
                        count_q   <= count_q + COUNT_WIDTH'(1);
                        ptr_q     <= ptr_next;
                    end
                end
                StRelease: begin
                    ack_out_q <= '0;
                end
                default: begin
                    ack_out_q <= '0;
                    req_up_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == StReq) || (state_q == StRelease);
        ack_out   = ack_out_q;
        dout      = dout_q;
        req_up    = req_up_q;
        grant_id  = grant_id_q;
        count     = count_q;
        proto_err = proto_err_q;
    end

endmodule

// File: tb/tb_dataflow_rr_arbiter.sv
// Self-checking bench: source model pushes expected {id, data} on each ack it gives,
// a monitor pops and compares whenever the arbiter pulses ack_out.
module tb_dataflow_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req_in = '0;
    logic [NR-1:0] ack_out;
    logic [DW-1:0] dout;
    logic          req_up;
    logic          ack_up = 1'b0;
    logic [DW-1:0] din_up = '0;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic [31:0]   count;
    logic          proto_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   pulses [NR];
    exp_t sb [$];

    dataflow_rr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .ack_out  (ack_out),
        .dout     (dout),
        .req_up   (req_up),
        .ack_up   (ack_up),
        .din_up   (din_up),
        .grant_id (grant_id),
        .busy     (busy),
        .count    (count),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ack_out != '0) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 64'(ack_out), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("ack_out", 64'(ack_out), 64'(4'b0001 << e.id));
                check_eq("dout", 64'(dout), 64'(e.data));
                pulses[e.id]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        ack_up = 1'b0;
        req_in = '0;
        foreach (pulses[i]) pulses[i] = 0;
        step();
        step();
        check_eq("rst_req_up", 64'(req_up), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
    endtask

    task automatic wait_req_up(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_up) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check_eq("req_up_timeout", 64'd0, 64'd1);
    endtask

    // Waits for req_up, stalls wait_cycles, then acks one cycle with data.
    task automatic deliver(input int wait_cycles, input logic [31:0] data, input int exp_id,
                           input logic [NR-1:0] req_after);
        bit          ok;
        logic [IW-1:0] gid;
        exp_t        e;
        wait_req_up(ok);
        if (!ok) return;
        req_in = req_after;
        gid    = grant_id;
        check_eq("grant_id", 64'(gid), 64'(exp_id));
        for (int i = 0; i < wait_cycles; i++) begin
            check_eq("stall_req_up", 64'(req_up), 64'd1);
            check_eq("stall_ack_out", 64'(ack_out), 64'd0);
            check_eq("stall_grant", 64'(grant_id), 64'(gid));
            step();
        end
        ack_up = 1'b1;
        din_up = data;
        e.id   = exp_id;
        e.data = data;
        sb.push_back(e);
        step();
        ack_up = 1'b0;
        din_up = $urandom;
    endtask

    initial begin
        bit ok;
        int t0;
        int t1;

        // Single requester, zero-wait source.
        do_reset();
        req_in = 4'b0001;
        deliver(0, 32'h5, 0, 4'b0001);
        check_eq("t1_count", 64'(count), 64'd1);
        check_eq("t1_req_up_gap0", 64'(req_up), 64'd0);
        step();
        check_eq("t1_req_up_gap1", 64'(req_up), 64'd0);
        step();
        check_eq("t1_req_up_rearb", 64'(req_up), 64'd1);
        deliver(0, 32'h6, 0, 4'b0000);
        step();
        step();
        check_eq("t1_count2", 64'(count), 64'd2);
        check_eq("t1_proto_err", 64'(proto_err), 64'd0);

        // All four requesters held: strict rotation.
        do_reset();
        req_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            deliver(0, 32'(i), i % 4, (i == 7) ? 4'b0000 : 4'b1111);
        end
        step();
        step();
        check_eq("t2_count", 64'(count), 64'd8);
        for (int i = 0; i < NR; i++) check_eq("t2_pulses", 64'(pulses[i]), 64'd2);

        // Source stalls 10 cycles with other requesters waiting.
        do_reset();
        req_in = 4'b1111;
        deliver(10, 32'hC0DE, 0, 4'b1110);
        req_in = '0;
        step();
        step();
        check_eq("t3_count", 64'(count), 64'd1);

        // Granted requester withdraws mid-REQ; token still delivered.
        do_reset();
        req_in = 4'b0001;
        deliver(3, 32'hAB, 0, 4'b0000);
        step();
        step();
        check_eq("t4_count", 64'(count), 64'd1);
        check_eq("t4_busy_idle", 64'(busy), 64'd0);

        // Reset mid-REQ, then ack right on reset release.
        req_in = 4'b0010;
        wait_req_up(ok);
        rst = 1'b0;
        #1;
        check_eq("t5_req_up", 64'(req_up), 64'd0);
        check_eq("t5_ack_out", 64'(ack_out), 64'd0);
        check_eq("t5_dout", 64'(dout), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_count", 64'(count), 64'd0);
        check_eq("t5_grant_id", 64'(grant_id), 64'd0);
        check_eq("t5_proto_err_rst", 64'(proto_err), 64'd0);
        req_in = '0;
        step();
        rst    = 1'b1;
        ack_up = 1'b1;
        din_up = 32'hDEAD;
        step();
        ack_up = 1'b0;
        check_eq("t5_proto_err", 64'(proto_err), 64'd1);
        check_eq("t5_count_after", 64'(count), 64'd0);
        step();
        step();
        check_eq("t5_proto_sticky", 64'(proto_err), 64'd1);
        check_eq("t5_busy_after", 64'(busy), 64'd0);

        // Throughput: requesters 1 and 3 alternate under a zero-wait source.
        do_reset();
        req_in = 4'b1010;
        t0 = cyc;
        for (int i = 0; i < 5000; i++) begin
            deliver(0, 32'(i * 3 + 1), (i % 2 == 0) ? 1 : 3, (i == 4999) ? 4'b0000 : 4'b1010);
        end
        t1 = cyc;
        step();
        check_eq("t6_count", 64'(count), 64'd5000);
        check_eq("t6_throughput", 64'(5000 * 100 >= 33 * (t1 - t0)), 64'd1);
        check_eq("t6_pulses1", 64'(pulses[1]), 64'd2500);
        check_eq("t6_pulses3", 64'(pulses[3]), 64'd2500);
        check_eq("t6_proto_err", 64'(proto_err), 64'd0);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dataflow_rr_arbiter.md
# dataflow_rr_arbiter

- Round-robin arbiter that lets `NUM_REQ` dataflow requesters share one upstream source (producer port, `in` operator output, or shared register stage).
- Requesters and the source use the same req/ack token handshake as the dataflow graph: the requester holds `req` as a level, and the source answers with a single-cycle `ack` carrying valid data.
- The block serialises requests, forwards exactly one token per grant, routes the registered data and ack back to the granted requester, and counts delivered tokens for throughput benches.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: token width.
- `ID_WIDTH`, 2: width of `grant_id`; must equal clog2(`NUM_REQ`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_in`  in  `NUM_REQ`  level request per requester.
- `ack_out`  out  `NUM_REQ`  one-cycle ack to the granted requester; one-hot or zero.
- `dout`  out  `DATA_WIDTH`  token; valid only while any `ack_out` bit is high.
- `req_up`  out  1  request to the shared source.
- `ack_up`  in  1  one-cycle ack from the source.
- `din_up`  in  `DATA_WIDTH`  source data; sampled only when `ack_up`=1.
- `grant_id`  out  `ID_WIDTH`  index of the current or last grant.
- `busy`  out  1  high in the REQ and RELEASE states.
- `count`  out  32  tokens delivered since reset; wraps modulo 2^32.
- `proto_err`  out  1  sticky flag for an `ack_up` received outside the REQ state.

## Operation
- FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - If `req_in` is nonzero, pick the first set bit scanning upward from `ptr`, wrapping modulo `NUM_REQ`.
  - Register the pick into `grant_id`, set `req_up`=1, go to REQ.
  - If `req_in` is zero, stay in IDLE.
- REQ:
  - Hold `req_up`=1 until `ack_up`=1.
  - On `ack_up`: `dout`<=`din_up`, `ack_out[grant_id]`<=1, `req_up`<=0, `count`<=`count`+1, `ptr`<=`grant_id`+1 (mod `NUM_REQ`), go to RELEASE.
  - A requester that drops `req_in` while in REQ does not cancel the grant. The source may already be committed, so the token is still delivered and the ack still pulses.
- RELEASE:
  - Lasts exactly one cycle; `ack_out` is high during it.
  - `req_in` is ignored here, because the granted requester's req is still stale.
  - Clear `ack_out`, go to IDLE.
- `ack_up`=1 in IDLE or RELEASE: the data is discarded, `count` is unchanged, and `proto_err`<=1. Only reset clears `proto_err`.
- Reset (async, `rst`=0):
  - State IDLE, `ptr`=0, `grant_id`=0.
  - `req_up`=0, `ack_out`=0, `dout`=0, `busy`=0, `count`=0, `proto_err`=0.
  - This takes effect immediately, including mid-REQ. Any in-flight source ack after release is a `proto_err` case.

## Timing
- All outputs are registered.
- Uncontended request: `req_in` sampled high at edge t gives `req_up`=1 after t.
- Source acks at edge t+k (k≥1): `ack_out` and `dout` are valid for the cycle after t+k, and `req_up` is low from the same point.
- Re-arbitration samples `req_in` at edge t+k+2. This gives a standard requester one cycle to drop its req after seeing `ack_out`.
- Throughput: at most one token every 3 cycles with a zero-wait source (ack one cycle after `req_up`).
- Fairness: with all `NUM_REQ` requesters continuously asserted, grants cycle 0,1,..,N-1,0. A requester waits for at most `NUM_REQ`-1 other grants.
- Simultaneous events:
  - `ack_up` and a new `req_in` in the same REQ cycle: the new req is held and arbitrated in the next IDLE.
  - `ack_up` exactly on reset release: ignored, because the state is IDLE, and `proto_err` sets.

## Structure
- Package `dataflow_arb_pkg`:
  - FSM state enum (IDLE, REQ, RELEASE).
  - Maximum `NUM_REQ` constant (16).
  - Count width constant (32).
- Sub-module `rr_picker`: combinational rotate-by-`ptr` priority encoder.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `valid` and `idx`.
  - It is reused by the planned multi-source scheduler.

## Test plan
- Single requester, source acks 1 cycle after `req_up`, `din_up`=0x0000_0005: `ack_out`=0001 with `dout`=5 in one cycle, `count`=1, next `req_up` no earlier than 2 cycles later.
- All four requesters held high, 8 tokens with values 0..7: grant order 0,1,2,3,0,1,2,3; each `ack_out` bit pulses twice; `count`=8.
- Source stalls 10 cycles in REQ: `req_up` stays high 10 cycles, `ack_out` stays 0, `grant_id` is stable, and no re-arbitration occurs despite other requests.
- Granted requester drops `req_in` mid-REQ, then ack with 0xAB: `ack_out` still pulses with `dout`=0xAB and `count` increments.
- Reset asserted mid-REQ, then `ack_up` pulsed after reset release: all outputs return to reset values immediately, `proto_err`=1, `count`=0.
- Run 5000 tokens with requesters 1 and 3 only: the two requesters alternate, `count`=5000, and measured throughput is ≥33% of clock cycles with a zero-wait source.
